shake_squeeze_dump: RTL and testbench
=====================================

# shake_squeeze_dump

Parametrised output-dump controller for the SHAKE core. It loads rate blocks from the permutation state in parallel and streams them out as W-bit words over a valid/ready interface. It tracks the requested output length in bytes, and requests further permutations (squeezes) ahead of time, so block N+1 is computed while block N drains. It sits between the Keccak permutation/state register and the core's external output port, and supports SHAKE128 and SHAKE256 rates selected at run time.

## Interface
- `W`, 64, output word width in bits; legal values 8, 16, 32, 64 (each divides both rates).
- `LEN_W`, 32, width of the output-length field, in bytes.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a squeeze job; sampled only in IDLE.
- `mode`  in  1  rate select, sampled with `start`: 0 = SHAKE128 (168 B, 1344 bits), 1 = SHAKE256 (136 B, 1088 bits).
- `out_len_in`  in  LEN_W  total output bytes requested, sampled with `start`.
- `block_in`  in  1344  rate portion of the state; `block_in[W-1:0]` is emitted first. Bits [1343:1088] are ignored in mode 1.
- `block_valid_in`  in  1  `block_in` holds a fresh block.
- `block_ready_out`  out  1  controller can load a block.
- `squeeze_req_out`  out  1  one-cycle pulse: permutation must produce the next block.
- `data_out`  out  W  output word.
- `keep_out`  out  W/8  byte enables for `data_out`; bit i covers `data_out[8i+7:8i]`.
- `valid_out`  out  1  `data_out` is valid.
- `ready_in`  in  1  downstream accepts a word.
- `last_out`  out  1  current word is the final word of the job.
- `busy_out`  out  1  high in any state other than IDLE.
- `done_out`  out  1  one-cycle pulse at job end.

## Operation
- Derived constants:
  - WB = W/8.
  - RW = 1344/W in mode 0, 1088/W in mode 1.
  - RB = RW*WB.
- Registers:
  - state.
  - `rem`: bytes remaining, LEN_W bits.
  - `wcnt`: words left in the current block, 0..1344/W.
  - shift register: 1344 bits.
  - mode latch.
- FSM states: IDLE, WAIT_BLOCK, DUMP, DONE.
- IDLE:
  - `start`=1 latches `mode` and loads `rem` = `out_len_in`.
  - Next state is DONE if `out_len_in`==0, else WAIT_BLOCK.
- WAIT_BLOCK:
  - `block_ready_out`=1.
  - On `block_valid_in`: load the shift register with `block_in`, set `wcnt` = min(RW, ceil(`rem`/WB)), set an internal flag `sq` = (`rem` > RB), then go to DUMP.
- DUMP:
  - `valid_out`=1 and `data_out` = shift register [W-1:0].
  - `squeeze_req_out` = `sq` in the first DUMP cycle only; clear `sq` afterwards.
  - On `valid_out && ready_in`:
    - shift right by W;
    - `wcnt`--;
    - `rem` -= min(WB, `rem`).
    - If `wcnt` was 1: go to DONE when the new `rem`==0, else go to WAIT_BLOCK.
- DONE: `done_out`=1 for one cycle, then go to IDLE.
- `keep_out`:
  - all ones when `rem` >= WB;
  - otherwise (1<<`rem`)-1, i.e. the low `rem` bytes.
- `last_out` = `valid_out` && (`rem` <= WB).
- `keep_out` and `last_out` are driven combinationally from the registered `rem`.
- `rem` arithmetic is unsigned. It never underflows because the decrement is clamped to `rem`.
- `start` outside IDLE is ignored. `block_valid_in` outside WAIT_BLOCK is ignored.

## Timing
- Reset (`rst_n`=0, at any time, including mid-job):
  - state = IDLE; `rem`, `wcnt`, `sq` and the shift register are cleared.
  - All outputs are 0: `block_ready_out`, `squeeze_req_out`, `valid_out`, `last_out`, `busy_out`, `done_out`, `data_out`; `keep_out` is also 0.
  - The job is discarded; there is no `done_out` for it.
- `start` to `block_ready_out`: 1 cycle.
- Block handshake to first `valid_out`: 1 cycle. `squeeze_req_out` pulses in that same cycle.
- Throughput is 1 word/cycle while `ready_in`=1.
- Inter-block gap: at least 1 cycle (the WAIT_BLOCK cycle), even if `block_valid_in` is already high.
- While `valid_out`=1 and `ready_in`=0, `data_out`, `keep_out` and `last_out` hold stable.
- Final accepted word to `done_out`: 1 cycle. `done_out` to IDLE (`busy_out`=0): 1 cycle.
- `out_len_in`=0: `start`, then DONE (`done_out`=1) on the next cycle; no block is requested or loaded.
- Exact multiple of RB: the last block sets no `sq`, so no extra squeeze is issued, and `keep_out` is all ones on the final word.

## Test plan
- SHAKE128, W=64, len=32 -> one block handshake; 4 words; `keep_out`=0xFF on all 4; `last_out` on the 4th only; `squeeze_req_out` never pulses; `done_out` 1 cycle after the 4th beat.
- SHAKE128, W=64, len=200 -> block 1 gives 21 words and `squeeze_req_out` pulses once in the first DUMP cycle; block 2 gives 4 words; `last_out`+`keep_out`=0xFF on word 25; exactly 2 block handshakes.
- SHAKE256, W=64, len=138 -> 17 words then 1 word with `keep_out`=0x03 and `last_out`=1; block 2 bits above 1088 never appear on `data_out`.
- Random `ready_in` backpressure (50%) on len=168, mode 0 -> outputs stable while stalled; 21 words in order; one block; no squeeze.
- len=0 -> `done_out` pulses the cycle after `start`; `block_ready_out` and `valid_out` stay 0; a `start` while `busy_out`=1 is ignored (the first job's length is preserved).
- `rst_n` low mid-DUMP (word 10 of 21) -> all outputs 0 immediately (asynchronously); no `done_out`; a fresh job afterwards completes normally.

Source files
------------

// File: rtl/shake_squeeze_dump.sv
// SHAKE output dump: loads a rate block in parallel, streams it as W-bit words, and
// requests the next squeeze on the first beat of the block. Block handshake to first word is 1 cycle; words hold while ready_in=0.
module shake_squeeze_dump #(
    parameter int W     = 64,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] out_len_in,
    input  logic [1343:0]    block_in,
    input  logic             block_valid_in,
    output logic             block_ready_out,
    output logic             squeeze_req_out,
    output logic [W-1:0]     data_out,
    output logic [W/8-1:0]   keep_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             last_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int WB     = W / 8;
    localparam int WB_LOG = $clog2(WB);
    localparam int RW0    = 1344 / W;
    localparam int RW1    = 1088 / W;
    localparam int WC_W   = $clog2(RW0 + 1);

    localparam logic [LEN_W-1:0] RB0     = LEN_W'(RW0 * WB);
    localparam logic [LEN_W-1:0] RB1     = LEN_W'(RW1 * WB);
    localparam logic [LEN_W-1:0] WB_L    = LEN_W'(WB);
    localparam logic [LEN_W-1:0] WB_MASK = LEN_W'(WB - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLOCK = 2'd1,
        DUMP       = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  rem;
    logic [WC_W-1:0]   wcnt;
    logic [1343:0]     shreg;
    logic              mode_q;
    logic              sq;

    logic              fire;
    logic [LEN_W-1:0]  rem_dec;
    logic [LEN_W-1:0]  words_left;
    logic [LEN_W-1:0]  rw_cur;
    logic [LEN_W-1:0]  rb_cur;
    logic [WC_W-1:0]   wcnt_load;
    logic [1343:0]     blk_load;

    assign fire    = (state == DUMP) && ready_in;
    // Clamped decrement: the final partial word consumes only what is left.
    assign rem_dec = (rem >= WB_L) ? (rem - WB_L) : '0;

    assign words_left = (rem >> WB_LOG) + LEN_W'((rem & WB_MASK) != '0);
    assign rw_cur     = mode_q ? LEN_W'(RW1) : LEN_W'(RW0);
    assign rb_cur     = mode_q ? RB1 : RB0;
    assign wcnt_load  = (words_left < rw_cur) ? WC_W'(words_left) : WC_W'(rw_cur);
    assign blk_load   = mode_q ? {{256{1'b0}}, block_in[1087:0]} : block_in;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (out_len_in == '0) ? DONE : WAIT_BLOCK;
                end
            end
            WAIT_BLOCK: begin
                if (block_valid_in) begin
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                if (fire && (wcnt == WC_W'(1))) begin
                    state_nxt = (rem_dec == '0) ? DONE : WAIT_BLOCK;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            wcnt   <= '0;
            shreg  <= '0;
            mode_q <= 1'b0;
            sq     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        rem    <= out_len_in;
                    end
                end
                WAIT_BLOCK: begin
                    if (block_valid_in) begin
                        shreg <= blk_load;
                        wcnt  <= wcnt_load;
                        // Another block is needed only if this one cannot finish the job.
                        sq    <= (rem > rb_cur);
                    end
                end
                DUMP: begin
                    sq <= 1'b0;
                    if (fire) begin
                        shreg <= shreg >> W;
                        wcnt  <= wcnt - WC_W'(1);
                        rem   <= rem_dec;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid_out       = (state == DUMP);
    assign block_ready_out = (state == WAIT_BLOCK);
    assign squeeze_req_out = (state == DUMP) && sq;
    assign busy_out        = (state != IDLE);
    assign done_out        = (state == DONE);
    assign data_out        = valid_out ? shreg[W-1:0] : '0;
    assign last_out        = valid_out && (rem <= WB_L);

    always_comb begin
        keep_out = '0;
        for (int i = 0; i < WB; i++) begin
            keep_out[i] = (rem > LEN_W'(i));
        end
    end

endmodule

// File: tb/tb_shake_squeeze_dump.sv
// Directed bench for shake_squeeze_dump (W=64): a word-level model checks every valid beat.
module tb_shake_squeeze_dump;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [31:0]   out_len_in;
    logic [1343:0] block_in;
    logic          block_valid_in;
    logic          block_ready_out;
    logic          squeeze_req_out;
    logic [63:0]   data_out;
    logic [7:0]    keep_out;
    logic          valid_out;
    logic          ready_in;
    logic          last_out;
    logic          busy_out;
    logic          done_out;

    shake_squeeze_dump #(.W(64), .LEN_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .mode            (mode),
        .out_len_in      (out_len_in),
        .block_in        (block_in),
        .block_valid_in  (block_valid_in),
        .block_ready_out (block_ready_out),
        .squeeze_req_out (squeeze_req_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .last_out        (last_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Job context shared with the monitor
    logic [1343:0] blk [8];
    bit   j_mode;
    int   j_len;
    int   exp_total;
    int   widx, hs, sq_cnt, done_cnt, brdy_seen;
    int   cyc = 0;
    int   done_cyc, last_fire_cyc;
    logic [7:0] last_keep_act;
    bit   bp = 1'b0;
    bit   mon_on = 1'b0;
    bit   hs_pend = 1'b0;
    bit   fire_pend = 1'b0;

    assign block_in = blk[hs[2:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int words_per_block(input bit m);
        return m ? 17 : 21;
    endfunction

    function automatic logic [63:0] model_data(input int k);
        int rw = words_per_block(j_mode);
        return blk[k / rw][(k % rw) * 64 +: 64];
    endfunction

    function automatic int model_rem(input int k);
        return j_len - k * 8;
    endfunction

    function automatic logic [7:0] model_keep(input int k);
        int r = model_rem(k);
        logic [8:0] t;
        if (r >= 8) return 8'hFF;
        t = (9'd1 << r) - 9'd1;
        return t[7:0];
    endfunction

    // Samples 1 time unit after each rising edge; also owns ready_in.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (hs_pend) hs++;
            if (fire_pend) widx++;
            hs_pend   = 1'b0;
            fire_pend = 1'b0;
            if (mon_on) begin
                ready_in = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (block_ready_out) brdy_seen++;
                if (block_ready_out && block_valid_in) hs_pend = 1'b1;
                if (done_out) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (squeeze_req_out) begin
                    sq_cnt++;
                    chk("squeeze_on_block_first_word",
                        64'(valid_out && (widx % words_per_block(j_mode) == 0)), 64'd1);
                end
                if (valid_out) begin
                    if (widx >= exp_total) begin
                        chk("extra_word_index", 64'(widx), 64'(exp_total - 1));
                    end else begin
                        chk("data", data_out, model_data(widx));
                        chk("keep", 64'(keep_out), 64'(model_keep(widx)));
                        chk("last", 64'(last_out), 64'(model_rem(widx) <= 8));
                    end
                    if (ready_in) begin
                        fire_pend     = 1'b1;
                        last_fire_cyc = cyc;
                        if (widx == exp_total - 1) last_keep_act = keep_out;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_blocks();
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 42; c++) begin
                blk[b][c*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic launch(input bit m, input int len, input int e_words, input bit use_bp);
        j_mode = m;
        j_len = len;
        exp_total = e_words;
        fill_blocks();
        widx = 0; hs = 0; sq_cnt = 0; done_cnt = 0; brdy_seen = 0;
        done_cyc = -1; last_fire_cyc = -1; last_keep_act = 8'h00;
        bp = use_bp;
        mon_on = 1'b1;
        tick();
        mode = m;
        out_len_in = 32'(len);
        start = 1'b1;
        block_valid_in = 1'b1;
    endtask

    task automatic run_job(input bit m, input int len, input bit use_bp, input bit poke,
                           input int e_words, input int e_blocks, input int e_sq,
                           input logic [7:0] e_lastkeep);
        int  s;
        bit  done_ok;
        launch(m, len, e_words, use_bp);
        s = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy_out), 64'd1);
        if (len == 0) chk("done_next_cycle_len0", 64'(done_out), 64'd1);
        else          chk("block_ready_after_start", 64'(block_ready_out), 64'd1);
        if (poke) begin
            tick();
            tick();
            out_len_in = 32'd8;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        done_ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_out) begin
                done_ok = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", 64'(done_ok), 64'd1);
        if (done_ok) begin
            if (len == 0) chk("done_cycle", 64'(done_cyc), 64'(s + 1));
            else          chk("done_cycle", 64'(done_cyc), 64'(last_fire_cyc + 1));
        end
        tick();
        chk("busy_cleared", 64'(busy_out), 64'd0);
        chk("done_pulse_count", 64'(done_cnt), 64'd1);
        chk("word_count", 64'(widx), 64'(e_words));
        chk("block_handshakes", 64'(hs), 64'(e_blocks));
        chk("squeeze_count", 64'(sq_cnt), 64'(e_sq));
        if (len == 0) chk("no_block_ready_len0", 64'(brdy_seen), 64'd0);
        else          chk("final_keep", 64'(last_keep_act), 64'(e_lastkeep));
        block_valid_in = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"},   64'(valid_out),       64'd0);
        chk({tag, "_bready"},  64'(block_ready_out), 64'd0);
        chk({tag, "_squeeze"}, 64'(squeeze_req_out), 64'd0);
        chk({tag, "_last"},    64'(last_out),        64'd0);
        chk({tag, "_busy"},    64'(busy_out),        64'd0);
        chk({tag, "_done"},    64'(done_out),        64'd0);
        chk({tag, "_data"},    data_out,             64'd0);
        chk({tag, "_keep"},    64'(keep_out),        64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        out_len_in = '0;
        block_valid_in = 1'b0;
        ready_in = 1'b0;
        fill_blocks();
        hs = 0;
        tick();
        tick();
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // mode, len, backpressure, poke-start, words, blocks, squeezes, final keep
        run_job(1'b0,  32, 1'b0, 1'b1,  4, 1, 0, 8'hFF);
        run_job(1'b0, 200, 1'b0, 1'b0, 25, 2, 1, 8'hFF);
        run_job(1'b1, 138, 1'b0, 1'b0, 18, 2, 1, 8'h03);
        run_job(1'b0, 168, 1'b1, 1'b0, 21, 1, 0, 8'hFF);
        run_job(1'b0,   0, 1'b0, 1'b0,  0, 0, 0, 8'h00);
        run_job(1'b1, 272, 1'b1, 1'b0, 34, 2, 1, 8'hFF);
        run_job(1'b1,   5, 1'b0, 1'b0,  1, 1, 0, 8'h1F);

        // Reset in the middle of a block
        launch(1'b0, 168, 21, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (widx >= 10) break;
            tick();
        end
        chk("reached_word10", 64'(widx >= 10), 64'd1);
        #1;
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_done_in_reset", 64'(done_out), 64'd0);
        end
        block_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", 64'(busy_out), 64'd0);

        run_job(1'b0, 168, 1'b0, 1'b0, 21, 1, 0, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
